// File: rtl/rs_access_mem_queue.sv
// In-order memory-access reservation station: DEPTH-entry circular queue with writeback wakeup.
// Latency: allocate->issue 1 cycle; wakeup->issue 1 cycle (0 with RS_MEM_BYPASS_EN defined).
// Backpressure: head held until issue_ack_i; wen_i while full_o is dropped; flush_i overrides all.

`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef DATA_LEN
`define DATA_LEN 32
`endif
`ifndef RRF_SEL
`define RRF_SEL 6
`endif

module rs_access_mem_queue #(
    parameter int  DEPTH  = 4,
    parameter int  NUM_WB = 5,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic                          flush_i,
    input  logic                          wen_i,
    input  logic [`ADDR_LEN-1:0]          write_pc_i,
    input  logic [`DATA_LEN-1:0]          write_imm_i,
    input  logic [`DATA_LEN-1:0]          write_src_op_1_i,
    input  logic [`DATA_LEN-1:0]          write_src_op_2_i,
    input  logic                          write_valid_1_i,
    input  logic                          write_valid_2_i,
    input  logic [`RRF_SEL-1:0]           write_rrf_tag_i,
    input  logic                          write_dst_val_i,
    input  logic [NUM_WB*`DATA_LEN-1:0]   exe_result_i,
    input  logic [NUM_WB*`RRF_SEL-1:0]    exe_result_dst_i,
    input  logic [NUM_WB-1:0]             exe_result_valid_i,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [PTR_W:0]                count_o,
    output logic                          issue_valid_o,
    input  logic                          issue_ack_i,
    output logic [`DATA_LEN-1:0]          exe_src_op_1_o,
    output logic [`DATA_LEN-1:0]          exe_src_op_2_o,
    output logic [`ADDR_LEN-1:0]          exe_pc_o,
    output logic [`DATA_LEN-1:0]          exe_imm_o,
    output logic [`RRF_SEL-1:0]           exe_rrf_tag_o,
    output logic                          exe_dst_val_o
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    typedef struct packed {
        logic [`ADDR_LEN-1:0] pc;
        logic [`DATA_LEN-1:0] imm;
        logic [`RRF_SEL-1:0]  rrf_tag;
        logic                 dst_val;
        logic [`DATA_LEN-1:0] op1;
        logic [`DATA_LEN-1:0] op2;
        logic                 v1;
        logic                 v2;
    } ent_t;

    ent_t               ent_q [DEPTH];
    logic [DEPTH-1:0]   busy_q;
    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [PTR_W:0]     count_q;

    // Per-entry and allocation-path bus matches: {hit, value}
    logic [`DATA_LEN:0] wk1 [DEPTH];
    logic [`DATA_LEN:0] wk2 [DEPTH];
    logic [`DATA_LEN:0] cap1, cap2;
    ent_t               new_ent;
    ent_t               hd;
    logic               head_v1, head_v2;
    logic               do_alloc, do_pop;

    // Lowest-numbered valid bus whose tag matches wins; invalid buses never match.
    function automatic logic [`DATA_LEN:0] wb_match(
        input logic [`RRF_SEL-1:0]        tag,
        input logic [NUM_WB*`DATA_LEN-1:0] res,
        input logic [NUM_WB*`RRF_SEL-1:0]  dst,
        input logic [NUM_WB-1:0]           vld
    );
        logic [`DATA_LEN:0] m;
        m = '0;
        for (int k = NUM_WB-1; k >= 0; k--) begin
            if (vld[k] && dst[k*`RRF_SEL +: `RRF_SEL] == tag) begin
                m = {1'b1, res[k*`DATA_LEN +: `DATA_LEN]};
            end
        end
        return m;
    endfunction

    // Writeback matching for stored entries and for the entry being allocated
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wk1[i] = wb_match(ent_q[i].op1[`RRF_SEL-1:0], exe_result_i, exe_result_dst_i, exe_result_valid_i);
            wk2[i] = wb_match(ent_q[i].op2[`RRF_SEL-1:0], exe_result_i, exe_result_dst_i, exe_result_valid_i);
        end
        cap1 = wb_match(write_src_op_1_i[`RRF_SEL-1:0], exe_result_i, exe_result_dst_i, exe_result_valid_i);
        cap2 = wb_match(write_src_op_2_i[`RRF_SEL-1:0], exe_result_i, exe_result_dst_i, exe_result_valid_i);

        new_ent         = '0;
        new_ent.pc      = write_pc_i;
        new_ent.imm     = write_imm_i;
        new_ent.rrf_tag = write_rrf_tag_i;
        new_ent.dst_val = write_dst_val_i;
        new_ent.v1      = write_valid_1_i | cap1[`DATA_LEN];
        new_ent.v2      = write_valid_2_i | cap2[`DATA_LEN];
        new_ent.op1     = (!write_valid_1_i && cap1[`DATA_LEN]) ? cap1[`DATA_LEN-1:0] : write_src_op_1_i;
        new_ent.op2     = (!write_valid_2_i && cap2[`DATA_LEN]) ? cap2[`DATA_LEN-1:0] : write_src_op_2_i;
    end

    // Head presentation, issue qualification and queue control
    always_comb begin
        hd = ent_q[head_q];
`ifdef RS_MEM_BYPASS_EN
        head_v1        = hd.v1 | wk1[head_q][`DATA_LEN];
        head_v2        = hd.v2 | wk2[head_q][`DATA_LEN];
        exe_src_op_1_o = (!hd.v1 && wk1[head_q][`DATA_LEN]) ? wk1[head_q][`DATA_LEN-1:0] : hd.op1;
        exe_src_op_2_o = (!hd.v2 && wk2[head_q][`DATA_LEN]) ? wk2[head_q][`DATA_LEN-1:0] : hd.op2;
`else
        head_v1        = hd.v1;
        head_v2        = hd.v2;
        exe_src_op_1_o = hd.op1;
        exe_src_op_2_o = hd.op2;
`endif
        exe_pc_o      = hd.pc;
        exe_imm_o     = hd.imm;
        exe_rrf_tag_o = hd.rrf_tag;
        exe_dst_val_o = hd.dst_val;
        issue_valid_o = busy_q[head_q] & head_v1 & head_v2;
        full_o        = (count_q == DEPTH_C);
        empty_o       = (count_q == '0);
        count_o       = count_q;
        do_alloc      = wen_i & ~full_o;
        do_pop        = issue_ack_i & issue_valid_o;
    end

    // Queue state: reset clears everything, flush drops entries, else wakeup/alloc/pop
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            busy_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            busy_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy_q[i] && !ent_q[i].v1 && wk1[i][`DATA_LEN]) begin
                    ent_q[i].op1 <= wk1[i][`DATA_LEN-1:0];
                    ent_q[i].v1  <= 1'b1;
                end
                if (busy_q[i] && !ent_q[i].v2 && wk2[i][`DATA_LEN]) begin
                    ent_q[i].op2 <= wk2[i][`DATA_LEN-1:0];
                    ent_q[i].v2  <= 1'b1;
                end
            end
            // Tail slot is free whenever not full, so it never collides with wakeup or pop
            if (do_alloc) begin
                ent_q[tail_q]  <= new_ent;
                busy_q[tail_q] <= 1'b1;
                tail_q         <= tail_q + PTR_W'(1);
            end
            if (do_pop) begin
                busy_q[head_q] <= 1'b0;
                head_q         <= head_q + PTR_W'(1);
            end
            case ({do_alloc, do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_access_mem_queue.sv
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef DATA_LEN
`define DATA_LEN 32
`endif
`ifndef RRF_SEL
`define RRF_SEL 6
`endif

module tb_rs_access_mem_queue;
    localparam int DEPTH  = 4;
    localparam int NUM_WB = 5;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int AL = `ADDR_LEN;
    localparam int DL = `DATA_LEN;
    localparam int RS = `RRF_SEL;
`ifdef RS_MEM_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic reset_ni, flush_i, wen_i, issue_ack_i;
    logic [AL-1:0] write_pc_i;
    logic [DL-1:0] write_imm_i, write_src_op_1_i, write_src_op_2_i;
    logic write_valid_1_i, write_valid_2_i, write_dst_val_i;
    logic [RS-1:0] write_rrf_tag_i;
    logic [NUM_WB*DL-1:0] exe_result_i;
    logic [NUM_WB*RS-1:0] exe_result_dst_i;
    logic [NUM_WB-1:0]    exe_result_valid_i;
    logic full_o, empty_o, issue_valid_o, exe_dst_val_o;
    logic [PTR_W:0] count_o;
    logic [DL-1:0] exe_src_op_1_o, exe_src_op_2_o, exe_imm_o;
    logic [AL-1:0] exe_pc_o;
    logic [RS-1:0] exe_rrf_tag_o;

    logic [DL-1:0] bus_dat [NUM_WB];
    logic [RS-1:0] bus_tag [NUM_WB];
    logic          bus_vld [NUM_WB];

    rs_access_mem_queue #(.DEPTH(DEPTH), .NUM_WB(NUM_WB)) dut (
        .clk_i(clk), .reset_ni(reset_ni), .flush_i(flush_i), .wen_i(wen_i),
        .write_pc_i(write_pc_i), .write_imm_i(write_imm_i),
        .write_src_op_1_i(write_src_op_1_i), .write_src_op_2_i(write_src_op_2_i),
        .write_valid_1_i(write_valid_1_i), .write_valid_2_i(write_valid_2_i),
        .write_rrf_tag_i(write_rrf_tag_i), .write_dst_val_i(write_dst_val_i),
        .exe_result_i(exe_result_i), .exe_result_dst_i(exe_result_dst_i),
        .exe_result_valid_i(exe_result_valid_i),
        .full_o(full_o), .empty_o(empty_o), .count_o(count_o),
        .issue_valid_o(issue_valid_o), .issue_ack_i(issue_ack_i),
        .exe_src_op_1_o(exe_src_op_1_o), .exe_src_op_2_o(exe_src_op_2_o),
        .exe_pc_o(exe_pc_o), .exe_imm_o(exe_imm_o),
        .exe_rrf_tag_o(exe_rrf_tag_o), .exe_dst_val_o(exe_dst_val_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        exe_result_i       = '0;
        exe_result_dst_i   = '0;
        exe_result_valid_i = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            exe_result_i[k*DL +: DL]     = bus_dat[k];
            exe_result_dst_i[k*RS +: RS] = bus_tag[k];
            exe_result_valid_i[k]        = bus_vld[k];
        end
    end

    // Reference model: the queue contents as a plain list, oldest first
    typedef struct {
        logic [AL-1:0] pc;
        logic [DL-1:0] imm;
        logic [RS-1:0] tag;
        logic          dst;
        logic [DL-1:0] op1, op2;
        logic          v1, v2;
    } ent_t;

    ent_t q[$];
    bit   started = 0;
    bit   exp_iv;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // First valid bus (lowest index) carrying this tag
    function automatic bit bus_match(input logic [RS-1:0] tag, output logic [DL-1:0] val);
        bit hit = 0;
        val = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (!hit && bus_vld[k] && bus_tag[k] == tag) begin
                hit = 1;
                val = bus_dat[k];
            end
        end
        return hit;
    endfunction

    task automatic model_compare();
        logic [DL-1:0] o1, o2, bv;
        bit r1, r2;
        exp_iv = 0;
        if (!started) return;
        chk("count", 64'(count_o), 64'(q.size()));
        chk("full", 64'(full_o), 64'(q.size() == DEPTH));
        chk("empty", 64'(empty_o), 64'(q.size() == 0));
        if (q.size() > 0) begin
            r1 = q[0].v1; o1 = q[0].op1;
            r2 = q[0].v2; o2 = q[0].op2;
            if (BYP && !r1 && bus_match(q[0].op1[RS-1:0], bv)) begin r1 = 1; o1 = bv; end
            if (BYP && !r2 && bus_match(q[0].op2[RS-1:0], bv)) begin r2 = 1; o2 = bv; end
            exp_iv = r1 && r2;
            chk("issue_valid", 64'(issue_valid_o), 64'(exp_iv));
            chk("exe_pc", 64'(exe_pc_o), 64'(q[0].pc));
            chk("exe_imm", 64'(exe_imm_o), 64'(q[0].imm));
            chk("exe_tag", 64'(exe_rrf_tag_o), 64'(q[0].tag));
            chk("exe_dst", 64'(exe_dst_val_o), 64'(q[0].dst));
            if (exp_iv) begin
                chk("exe_op1", 64'(exe_src_op_1_o), 64'(o1));
                chk("exe_op2", 64'(exe_src_op_2_o), 64'(o2));
            end
        end else begin
            chk("issue_valid_empty", 64'(issue_valid_o), 64'd0);
        end
    endtask

    task automatic model_update();
        int n0;
        ent_t e;
        logic [DL-1:0] bv;
        if (!reset_ni) begin
            q.delete();
            started = 1;
            return;
        end
        if (!started) return;
        if (flush_i) begin
            q.delete();
            return;
        end
        n0 = q.size();
        for (int i = 0; i < q.size(); i++) begin
            e = q[i];
            if (!e.v1 && bus_match(e.op1[RS-1:0], bv)) begin e.v1 = 1; e.op1 = bv; end
            if (!e.v2 && bus_match(e.op2[RS-1:0], bv)) begin e.v2 = 1; e.op2 = bv; end
            q[i] = e;
        end
        if (issue_ack_i && exp_iv) void'(q.pop_front());
        if (wen_i && n0 < DEPTH) begin
            e.pc = write_pc_i; e.imm = write_imm_i; e.tag = write_rrf_tag_i; e.dst = write_dst_val_i;
            e.op1 = write_src_op_1_i; e.v1 = write_valid_1_i;
            e.op2 = write_src_op_2_i; e.v2 = write_valid_2_i;
            if (!e.v1 && bus_match(e.op1[RS-1:0], bv)) begin e.v1 = 1; e.op1 = bv; end
            if (!e.v2 && bus_match(e.op2[RS-1:0], bv)) begin e.v2 = 1; e.op2 = bv; end
            q.push_back(e);
        end
    endtask

    // Inputs are set just after the falling edge; compare, clock, then advance the model
    task automatic step();
        model_compare();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_idle();
        reset_ni = 1; flush_i = 0; wen_i = 0; issue_ack_i = 0;
        write_pc_i = '0; write_imm_i = '0; write_src_op_1_i = '0; write_src_op_2_i = '0;
        write_valid_1_i = 1; write_valid_2_i = 1; write_rrf_tag_i = '0; write_dst_val_i = 0;
        for (int k = 0; k < NUM_WB; k++) begin bus_dat[k] = '0; bus_tag[k] = '0; bus_vld[k] = 0; end
    endtask

    task automatic write_ready(input logic [AL-1:0] pc);
        wen_i = 1; write_pc_i = pc; write_imm_i = pc + 32'h1000;
        write_src_op_1_i = pc + 1; write_src_op_2_i = pc + 2;
        write_valid_1_i = 1; write_valid_2_i = 1;
        write_rrf_tag_i = pc[RS-1:0]; write_dst_val_i = pc[2];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        set_idle();
        reset_ni = 0; wen_i = 1;
        @(negedge clk);
        // Reset held two cycles with a write request pending
        for (int i = 0; i < 2; i++) begin
            set_idle(); reset_ni = 0; write_ready(32'h80); #1; step();
        end
        set_idle(); #1;
        chk("rst_empty", 64'(empty_o), 64'd1);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_iv", 64'(issue_valid_o), 64'd0);
        chk("rst_pc", 64'(exe_pc_o), 64'd0);
        chk("rst_op1", 64'(exe_src_op_1_o), 64'd0);
        chk("rst_op2", 64'(exe_src_op_2_o), 64'd0);
        chk("rst_imm", 64'(exe_imm_o), 64'd0);
        step();

        // Fill past capacity with no ack, then drain in order
        for (int i = 0; i < 5; i++) begin
            set_idle(); write_ready(32'h100 + 32'(4*i)); #1;
            if (i == 4) chk("fill_full", 64'(full_o), 64'd1);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            set_idle(); issue_ack_i = 1; #1;
            if (i == 0) chk("fill_count", 64'(count_o), 64'd4);
            chk("drain_iv", 64'(issue_valid_o), 64'd1);
            chk("drain_pc", 64'(exe_pc_o), 64'(32'h100 + 32'(4*i)));
            step();
        end
        set_idle(); #1;
        chk("drain_empty", 64'(empty_o), 64'd1);
        step();

        // Wakeup of op1 from bus 2
        set_idle(); write_ready(32'h200); write_valid_1_i = 0; write_src_op_1_i = 32'd7; #1; step();
        set_idle(); bus_vld[2] = 1; bus_tag[2] = 7; bus_dat[2] = 32'hDEAD; #1;
        chk("wk_iv_wbcycle", 64'(issue_valid_o), 64'(BYP));
        if (BYP) chk("wk_op1_bypass", 64'(exe_src_op_1_o), 64'hDEAD);
        step();
        set_idle(); issue_ack_i = 1; #1;
        chk("wk_iv_next", 64'(issue_valid_o), 64'd1);
        chk("wk_op1", 64'(exe_src_op_1_o), 64'hDEAD);
        step();

        // Allocation capture, lowest bus wins
        set_idle(); write_ready(32'h240); write_valid_2_i = 0; write_src_op_2_i = 32'd3;
        bus_vld[1] = 1; bus_tag[1] = 3; bus_dat[1] = 32'h11;
        bus_vld[4] = 1; bus_tag[4] = 3; bus_dat[4] = 32'h44; #1; step();
        set_idle(); issue_ack_i = 1; #1;
        chk("cap_iv", 64'(issue_valid_o), 64'd1);
        chk("cap_op2", 64'(exe_src_op_2_o), 64'h11);
        step();

        // Invalid bus never wakes; blocked head holds back a ready younger entry
        set_idle(); write_ready(32'h300); write_valid_1_i = 0; write_src_op_1_i = 32'd5; #1; step();
        set_idle(); write_ready(32'h304); #1; step();
        for (int i = 0; i < 2; i++) begin
            set_idle(); issue_ack_i = 1; bus_tag[0] = 5; bus_dat[0] = 32'h55; #1;
            chk("inv_iv", 64'(issue_valid_o), 64'd0);
            chk("inv_pc", 64'(exe_pc_o), 64'h300);
            step();
        end
        set_idle(); bus_vld[0] = 1; bus_tag[0] = 5; bus_dat[0] = 32'h55; #1; step();
        for (int i = 0; i < 2; i++) begin
            set_idle(); issue_ack_i = 1; #1;
            chk("ord_pc", 64'(exe_pc_o), 64'(32'h300 + 32'(4*i)));
            step();
        end

        // Flush overrides simultaneous write and ack
        for (int i = 0; i < 3; i++) begin set_idle(); write_ready(32'h400 + 32'(4*i)); #1; step(); end
        set_idle(); flush_i = 1; issue_ack_i = 1; write_ready(32'h4F0); #1; step();
        set_idle(); #1;
        chk("flush_count", 64'(count_o), 64'd0);
        chk("flush_empty", 64'(empty_o), 64'd1);
        step();
        set_idle(); write_ready(32'h500); #1; step();
        set_idle(); issue_ack_i = 1; #1;
        chk("post_flush_pc", 64'(exe_pc_o), 64'h500);
        step();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic [RS-1:0] t1, t2;
            set_idle();
            reset_ni = ($urandom_range(0, 199) != 0);
            flush_i  = ($urandom_range(0, 39) == 0);
            wen_i    = ($urandom_range(0, 9) < 6);
            issue_ack_i = ($urandom_range(0, 9) < 5);
            write_pc_i = $urandom; write_imm_i = $urandom;
            write_rrf_tag_i = RS'($urandom); write_dst_val_i = 1'($urandom);
            t1 = RS'($urandom_range(0, 7)); t2 = RS'($urandom_range(0, 7));
            write_valid_1_i = 1'($urandom); write_valid_2_i = 1'($urandom);
            write_src_op_1_i = write_valid_1_i ? DL'($urandom) : ((DL'($urandom) & ~DL'(63)) | DL'(t1));
            write_src_op_2_i = write_valid_2_i ? DL'($urandom) : ((DL'($urandom) & ~DL'(63)) | DL'(t2));
            for (int k = 0; k < NUM_WB; k++) begin
                bus_vld[k] = ($urandom_range(0, 9) < 3);
                bus_tag[k] = RS'($urandom_range(0, 7));
                bus_dat[k] = $urandom;
            end
            #1;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
